mult_div_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO result registers, the sequential companion to the single-cycle ALU in the MIPS datapath. It executes MULT/MULTU/DIV/DIVU over WIDTH-bit operands using one shift-add or shift-subtract step per clock, under a start/busy/done handshake. It also provides a direct HI/LO write path for MTHI/MTLO. Control stalls the pipeline on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 128 ++++++++++++
 tb/tb_mult_div_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One shift-add / restoring shift-subtract step per clock on operand magnitudes,
// signs re-applied in a final fix-up cycle.
module mult_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nx;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   mb;
  logic [WIDTH-1:0]   a_raw;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r, dbz;
  logic               accept, sa, sb, last;

  logic [WIDTH:0]     msum, trial, diff;
  logic [2*WIDTH-1:0] step_acc, prod;
  logic [WIDTH-1:0]   qv, rv;

  assign accept = (state == IDLE) && start;
  assign sa     = op[0] && a[WIDTH-1];
  assign sb     = op[0] && b[WIDTH-1];
  assign last   = (cnt == CW'(WIDTH-1));
  assign busy   = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // acc = {upper, lower}: multiply adds into upper and shifts right;
  // divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : {(WIDTH+1){1'b0}});
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff  = trial - {1'b0, mb};
    if (!op_q[1])
      step_acc = {msum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      step_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      step_acc = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod = neg_q ? -acc : acc;
    qv   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rv   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q        <= 2'b00;
      mb          <= '0;
      a_raw       <= '0;
      acc         <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= (state == FIX);
      if (accept) begin
        op_q        <= op;
        acc         <= {{WIDTH{1'b0}}, (sa ? -a : a)};
        mb          <= sb ? -b : b;
        neg_q       <= sa ^ sb;
        neg_r       <= sa;
        dbz         <= op[1] && (b == '0);
        a_raw       <= a;
        cnt         <= '0;
        div_by_zero <= 1'b0;
      end else if (state == IDLE) begin
        if (hilo_we[1]) hi <= hilo_wd;
        if (hilo_we[0]) lo <= hilo_wd;
      end
      if (state == RUN) begin
        acc <= step_acc;
        cnt <= cnt + CW'(1);
      end
      // A zero divisor bypasses sign fix-up so hi returns the dividend untouched.
      if (state == FIX) begin
        if (!op_q[1]) begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end else if (dbz) begin
          hi          <= a_raw;
          lo          <= '1;
          div_by_zero <= 1'b1;
        end else begin
          hi <= rv;
          lo <= qv;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
// Randomised and directed operations checked against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [1:0]   op, hilo_we;
  logic [W-1:0] a, b, hilo_wd;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clock = ~clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hilo_we(hilo_we), .hilo_wd(hilo_wd), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // returns {div_by_zero, hi, lo}
  function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic signed [31:0] sx, sy, q, r;
    logic [31:0] p;
    sx = {{16{x[15]}}, x};
    sy = {{16{y[15]}}, y};
    case (o)
      2'd0: begin p = {16'b0, x} * {16'b0, y}; return {1'b0, p}; end
      2'd1: begin p = sx * sy; return {1'b0, p}; end
      default: begin
        if (y == 16'h0) return {1'b1, x, 16'hFFFF};
        if (o == 2'd2) begin
          q = {16'b0, x} / {16'b0, y};
          r = {16'b0, x} % {16'b0, y};
        end else begin
          q = sx / sy;
          r = sx % sy;
        end
        return {1'b0, r[15:0], q[15:0]};
      end
    endcase
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input bit disturb);
    logic [32:0] m;
    int lat, busy_cycles, dones;
    m = model(o, x, y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    hilo_we = disturb ? 2'b11 : 2'b00; hilo_wd = 16'hBEEF;
    @(negedge clock);
    start = 1'b0; hilo_we = 2'b00; a = 16'($urandom); b = 16'($urandom);
    check("busy_after_start", busy, 1);
    check("dbz_cleared", div_by_zero, 0);
    check("hi_hold_start", hi, exp_hi);
    check("lo_hold_start", lo, exp_lo);
    busy_cycles = 1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cycles++;
      if (k == 10) begin
        check("hi_hold_run", hi, exp_hi);
        check("lo_hold_run", lo, exp_lo);
      end
      if (disturb && k == 5) begin
        start = 1'b1; op = ~o; a = 16'h0007; b = 16'h0003;
        hilo_we = 2'b11; hilo_wd = 16'h1234;
      end else begin
        start = 1'b0; hilo_we = 2'b00;
      end
    end
    check("latency", lat, W + 1);
    check("busy_cycles", busy_cycles, W + 1);
    check("busy_at_done", busy, 0);
    check("hi", hi, m[31:16]);
    check("lo", lo, m[15:0]);
    check("dbz", div_by_zero, m[32]);
    exp_hi = m[31:16];
    exp_lo = m[15:0];
    dones = 0;
    repeat (W + 4) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("no_extra_done", dones, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [15:0] rx, ry;
    int dones;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hilo_we = 2'b00; hilo_wd = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;

    run_op(2'd0, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(2'd1, 16'hFFFD, 16'h0005, 1'b0);
    run_op(2'd3, 16'hFFF9, 16'h0002, 1'b0);
    run_op(2'd3, 16'h8000, 16'hFFFF, 1'b0);
    run_op(2'd2, 16'h0064, 16'h0000, 1'b0);
    run_op(2'd0, 16'h0002, 16'h0003, 1'b0);
    run_op(2'd3, 16'h8000, 16'h0000, 1'b0);
    run_op(2'd2, 16'h1000, 16'h0007, 1'b1);

    @(negedge clock); hilo_we = 2'b11; hilo_wd = 16'h1234;
    @(negedge clock); hilo_we = 2'b00;
    check("we_hi", hi, 16'h1234);
    check("we_lo", lo, 16'h1234);
    @(negedge clock); hilo_we = 2'b10; hilo_wd = 16'hABCD;
    @(negedge clock); hilo_we = 2'b00;
    check("we_hi_only", hi, 16'hABCD);
    check("we_lo_kept", lo, 16'h1234);
    exp_hi = 16'hABCD;
    exp_lo = 16'h1234;

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = pick();
      ry = pick();
      run_op(ro, rx, ry, 1'b0);
    end

    @(negedge clock); hilo_we = 2'b11; hilo_wd = 16'h5555;
    @(negedge clock); hilo_we = 2'b00;
    start = 1'b1; op = 2'd2; a = 16'h1000; b = 16'h0003;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    reset = 1'b0;
    dones = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
